// File: rtl/kbdmus_port_if.sv
// Bus between the AVR SPI slave / Z80 port decode (master) and kbdmus_port (slave).
// Carries keyboard matrix, mouse bytes, Z80 row selects and the port read data.
interface kbdmus_port_if;
    logic [39:0] kbd_in;
    logic        kbd_stb;
    logic [7:0]  mus_in;
    logic        mus_xstb;
    logic        mus_ystb;
    logic        mus_btnstb;
    logic        kbd_rd_hold;
    logic [7:0]  zah;
    logic [4:0]  kbd_data;
    logic [7:0]  mus_x;
    logic [7:0]  mus_y;
    logic [7:0]  mus_btn;
    logic        kbd_timeout;

    modport master (
        output kbd_in, kbd_stb, mus_in, mus_xstb, mus_ystb, mus_btnstb, kbd_rd_hold, zah,
        input  kbd_data, mus_x, mus_y, mus_btn, kbd_timeout
    );

    modport slave (
        input  kbd_in, kbd_stb, mus_in, mus_xstb, mus_ystb, mus_btnstb, kbd_rd_hold, zah,
        output kbd_data, mus_x, mus_y, mus_btn, kbd_timeout
    );
endinterface

// File: rtl/kbdmus_port.sv
// Z80-side keyboard matrix / Kempston mouse holder fed by the AVR SPI slave.
// Matrix updates are deferred during a port #FE read; keys release on refresh timeout.
module kbdmus_port #(
    parameter int unsigned TO_WIDTH  = 24,
    parameter int unsigned TO_CYCLES = 14000000
) (
    input  logic         i_fclk,
    input  logic         i_rst,
    kbdmus_port_if.slave io_bus
);

    localparam logic [39:0]         LP_ALL1 = 40'hFF_FFFF_FFFF;
    localparam logic [TO_WIDTH-1:0] LP_TO   = TO_WIDTH'(TO_CYCLES);

    logic [39:0]         r_active;
    logic [39:0]         r_pending;
    logic                r_pflag;
    logic [TO_WIDTH-1:0] r_cnt;
    logic                r_timeout;
    logic [7:0]          r_mus_x;
    logic [7:0]          r_mus_y;
    logic [7:0]          r_mus_btn;

    logic [39:0]         w_active_nxt;
    logic [39:0]         w_pending_nxt;
    logic                w_pflag_nxt;
    logic [TO_WIDTH-1:0] w_cnt_nxt;
    logic                w_timeout_nxt;
    logic                w_to_event;
    logic [4:0]          w_kbd_data;

    // Exactly one event per stall: only the edge that moves the counter onto TO_CYCLES.
    assign w_to_event = !io_bus.kbd_stb && (LP_TO != '0) && (r_cnt == LP_TO - TO_WIDTH'(1));

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = r_timeout;
        if (io_bus.kbd_stb) begin
            w_cnt_nxt     = '0;
            w_timeout_nxt = 1'b0;
        end else if (r_cnt < LP_TO) begin
            w_cnt_nxt = r_cnt + TO_WIDTH'(1);
            if (w_to_event) begin
                w_timeout_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        w_active_nxt  = r_active;
        w_pending_nxt = r_pending;
        w_pflag_nxt   = r_pflag;
        if (io_bus.kbd_stb && !io_bus.kbd_rd_hold) begin
            w_active_nxt = io_bus.kbd_in;
            w_pflag_nxt  = 1'b0;
        end else if (io_bus.kbd_stb) begin
            w_pending_nxt = io_bus.kbd_in;
            w_pflag_nxt   = 1'b1;
        end else if (w_to_event && !io_bus.kbd_rd_hold) begin
            w_active_nxt = LP_ALL1;
            w_pflag_nxt  = 1'b0;
        end else if (w_to_event) begin
            w_pending_nxt = LP_ALL1;
            w_pflag_nxt   = 1'b1;
        end else if (r_pflag && !io_bus.kbd_rd_hold) begin
            w_active_nxt = r_pending;
            w_pflag_nxt  = 1'b0;
        end
    end

    always_ff @(posedge i_fclk) begin
        if (i_rst) begin
            r_active  <= LP_ALL1;
            r_pending <= LP_ALL1;
            r_pflag   <= 1'b0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_mus_x   <= 8'h00;
            r_mus_y   <= 8'h00;
            r_mus_btn <= 8'hFF;
        end else begin
            r_active  <= w_active_nxt;
            r_pending <= w_pending_nxt;
            r_pflag   <= w_pflag_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
            if (io_bus.mus_xstb) begin
                r_mus_x <= io_bus.mus_in;
            end
            if (io_bus.mus_ystb) begin
                r_mus_y <= io_bus.mus_in;
            end
            if (io_bus.mus_btnstb) begin
                r_mus_btn <= io_bus.mus_in;
            end
        end
    end

    // Several selected rows AND together, as on a real matrix.
    always_comb begin
        w_kbd_data = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            if (!io_bus.zah[r]) begin
                w_kbd_data = w_kbd_data & r_active[5*r +: 5];
            end
        end
    end

    assign io_bus.kbd_data    = w_kbd_data;
    assign io_bus.mus_x       = r_mus_x;
    assign io_bus.mus_y       = r_mus_y;
    assign io_bus.mus_btn     = r_mus_btn;
    assign io_bus.kbd_timeout = r_timeout;

endmodule

// File: tb/tb_kbdmus_port.sv
// Self-checking bench for kbdmus_port: directed scenarios plus random traffic,
// compared every cycle against a key-level behavioural model.
module tb_kbdmus_port;

    localparam int unsigned TO = 10;
    localparam logic [39:0] ALL1 = 40'hFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kbdmus_port_if u_if();

    kbdmus_port #(
        .TO_WIDTH (24),
        .TO_CYCLES(TO)
    ) u_dut (
        .i_fclk(clk),
        .i_rst (rst),
        .io_bus(u_if)
    );

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    // Model state: what the Z80 should see, in terms of keys and idle time.
    logic [39:0] m_active, m_pend;
    bit          m_pflag;
    int unsigned m_idle;
    logic [7:0]  m_x, m_y, m_b;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // A column reads 0 if any selected row has that key pressed.
    function automatic logic [4:0] exp_kbd(input logic [39:0] mat, input logic [7:0] zah);
        logic [4:0] res;
        res = 5'b11111;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 8; r++)
                if (!zah[r] && !mat[5*r+c]) res[c] = 1'b0;
        return res;
    endfunction

    function automatic logic [39:0] press(input int k);
        logic [39:0] v;
        v = ALL1;
        v[k] = 1'b0;
        return v;
    endfunction

    task automatic model_update();
        bit ev, stb, hold;
        stb  = u_if.kbd_stb;
        hold = u_if.kbd_rd_hold;
        if (rst) begin
            m_active = ALL1; m_pend = ALL1; m_pflag = 0; m_idle = 0;
            m_x = 8'h00; m_y = 8'h00; m_b = 8'hFF;
            return;
        end
        ev = !stb && (m_idle + 1 == TO);
        if (stb) m_idle = 0;
        else if (m_idle < TO) m_idle++;
        if (stb && !hold)        begin m_active = u_if.kbd_in; m_pflag = 0; end
        else if (stb)            begin m_pend = u_if.kbd_in;   m_pflag = 1; end
        else if (ev && !hold)    begin m_active = ALL1;        m_pflag = 0; end
        else if (ev)             begin m_pend = ALL1;          m_pflag = 1; end
        else if (m_pflag && !hold) begin m_active = m_pend;    m_pflag = 0; end
        if (u_if.mus_xstb)   m_x = u_if.mus_in;
        if (u_if.mus_ystb)   m_y = u_if.mus_in;
        if (u_if.mus_btnstb) m_b = u_if.mus_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.kbd_stb = 0; u_if.mus_xstb = 0; u_if.mus_ystb = 0; u_if.mus_btnstb = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("kbd_data", 40'(u_if.kbd_data), 40'(exp_kbd(m_active, u_if.zah)));
            check("mus_x", 40'(u_if.mus_x), 40'(m_x));
            check("mus_y", 40'(u_if.mus_y), 40'(m_y));
            check("mus_btn", 40'(u_if.mus_btn), 40'(m_b));
            check("kbd_timeout", 40'(u_if.kbd_timeout), 40'(m_idle >= TO));
        end
    end

    initial begin
        int stb_pct;
        rst = 1;
        u_if.kbd_in = ALL1; u_if.mus_in = 8'h00; u_if.kbd_rd_hold = 0; u_if.zah = 8'hFF;
        idle_inputs();
        tick();
        tick();
        chk_en = 1;
        rst = 0;
        u_if.zah = 8'h00;
        #1;
        // 1: reset state
        check("rst_kbd", 40'(u_if.kbd_data), 40'h1F);
        check("rst_x", 40'(u_if.mus_x), 40'h00);
        check("rst_y", 40'(u_if.mus_y), 40'h00);
        check("rst_btn", 40'(u_if.mus_btn), 40'hFF);
        check("rst_to", 40'(u_if.kbd_timeout), 40'h0);

        // 2: Caps Shift
        u_if.kbd_in = press(0); u_if.kbd_stb = 1;
        tick();
        idle_inputs();
        u_if.zah = 8'hFE; #1;
        check("cs_fe", 40'(u_if.kbd_data), 40'h1E);
        check("cs_model", 40'(exp_kbd(m_active, 8'hFE)), 40'h1E);
        u_if.zah = 8'hFD; #1;
        check("cs_fd", 40'(u_if.kbd_data), 40'h1F);
        u_if.zah = 8'h00; #1;
        check("cs_00", 40'(u_if.kbd_data), 40'h1E);

        // 3: deferred update during hold, later strobe wins
        u_if.zah = 8'hFD; u_if.kbd_rd_hold = 1;
        u_if.kbd_in = press(5); u_if.kbd_stb = 1;
        tick();
        u_if.kbd_in = press(6);
        tick();
        idle_inputs();
        tick();
        check("hold_frozen", 40'(u_if.kbd_data), 40'h1F);
        u_if.kbd_rd_hold = 0; #1;
        check("hold_fall_pre", 40'(u_if.kbd_data), 40'h1F);
        tick();
        check("hold_commit", 40'(u_if.kbd_data), 40'h1D);
        check("hold_model", 40'(exp_kbd(m_active, 8'hFD)), 40'h1D);

        // 4: strobe on the hold-fall edge supersedes pending
        u_if.kbd_rd_hold = 1; u_if.kbd_in = press(5); u_if.kbd_stb = 1;
        tick();
        u_if.kbd_rd_hold = 0; u_if.kbd_in = press(7);
        tick();
        idle_inputs();
        tick();
        check("supersede", 40'(u_if.kbd_data), 40'h1B);

        // 5: refresh timeout
        u_if.zah = 8'hFE; u_if.kbd_in = press(0); u_if.kbd_stb = 1;
        tick();
        idle_inputs();
        for (int i = 0; i < 9; i++) tick();
        check("to_pre_kbd", 40'(u_if.kbd_data), 40'h1E);
        check("to_pre_flag", 40'(u_if.kbd_timeout), 40'h0);
        tick();
        check("to_kbd", 40'(u_if.kbd_data), 40'h1F);
        check("to_flag", 40'(u_if.kbd_timeout), 40'h1);
        check("to_model", 40'(m_idle >= TO), 40'h1);
        for (int i = 0; i < 5; i++) tick();
        check("to_sat", 40'(u_if.kbd_timeout), 40'h1);
        u_if.kbd_in = press(1); u_if.kbd_stb = 1;
        tick();
        idle_inputs();
        check("to_clear", 40'(u_if.kbd_timeout), 40'h0);
        check("to_new", 40'(u_if.kbd_data), 40'h1D);

        // 6: mouse
        u_if.mus_in = 8'h5A; u_if.mus_xstb = 1;
        tick();
        idle_inputs();
        u_if.mus_in = 8'hA5; u_if.mus_ystb = 1; u_if.mus_btnstb = 1;
        tick();
        idle_inputs();
        check("mus_x", 40'(u_if.mus_x), 40'h5A);
        check("mus_y", 40'(u_if.mus_y), 40'hA5);
        check("mus_btn", 40'(u_if.mus_btn), 40'hA5);
        rst = 1; u_if.mus_in = 8'h77; u_if.mus_xstb = 1;
        tick();
        rst = 0; idle_inputs();
        check("rst_wins_x", 40'(u_if.mus_x), 40'h00);
        check("rst_wins_btn", 40'(u_if.mus_btn), 40'hFF);

        // Random traffic with varying strobe density so timeouts also occur under hold.
        stb_pct = 30;
        for (int n = 0; n < 4000; n++) begin
            if (n % 150 == 0) begin
                case ($urandom_range(2))
                    0: stb_pct = 0;
                    1: stb_pct = 5;
                    default: stb_pct = 40;
                endcase
            end
            rst = ($urandom_range(299) == 0);
            u_if.kbd_stb = ($urandom_range(99) < stb_pct);
            u_if.kbd_in = ~({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            if ($urandom_range(5) == 0) u_if.kbd_rd_hold = ~u_if.kbd_rd_hold;
            case ($urandom_range(3))
                0: u_if.zah = 8'hFF;
                1: u_if.zah = 8'h00;
                default: u_if.zah = 8'($urandom);
            endcase
            u_if.mus_in = 8'($urandom);
            u_if.mus_xstb = ($urandom_range(7) == 0);
            u_if.mus_ystb = ($urandom_range(7) == 0);
            u_if.mus_btnstb = ($urandom_range(7) == 0);
            tick();
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
